// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed seven-segment driver for the 32-bit display word, with frame-boundary commit.
// Optional build macro SEG7_ZERO_BLANK_EN: blank leading-zero digits (digit 0 and DP-lit digits always shown).
//
// state  | meaning
// S_DIG0 | digit 0 (data[3:0], rightmost) selected
// S_DIG1 | digit 1 selected
// S_DIG2 | digit 2 selected
// S_DIG3 | digit 3 selected
// S_DIG4 | digit 4 selected
// S_DIG5 | digit 5 selected
// S_DIG6 | digit 6 selected
// S_DIG7 | digit 7 selected; leaving it is the frame commit point
module seg7_scan_driver #(
  parameter int SCAN_DIV       = 100000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        load,
  input  logic [31:0] data,
  input  logic [7:0]  dp,
  input  logic        enable,
  output logic [7:0]  digitalLocation,
  output logic [7:0]  digitalStates,
  output logic        scan_tick,
  output logic        frame_sync
);

  localparam int              DW      = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0]   DIV_TC  = DW'(SCAN_DIV - 1);
  localparam logic [7:0]      AN_OFF  = AN_ACTIVE_LOW  ? 8'hFF : 8'h00;
  localparam logic [7:0]      SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

  typedef enum logic [2:0] {
    S_DIG0, S_DIG1, S_DIG2, S_DIG3, S_DIG4, S_DIG5, S_DIG6, S_DIG7
  } scan_state_e;

  scan_state_e   state, state_nxt;
  logic [2:0]    dig_idx;
  logic [DW-1:0] div_cnt;
  logic          adv, wrap;

  logic [31:0]   shadow, disp;
  logic [7:0]    shadow_dp, disp_dp;
  logic          pending;

  logic [31:0]   disp_sh;
  logic [7:0]    seg_raw, seg_nxt, loc_raw, loc_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign dig_idx = state;
  assign adv     = (div_cnt == DIV_TC);
  assign wrap    = adv && (state == S_DIG7);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      div_cnt <= '0;
    end else if (adv) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= S_DIG0;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (adv) begin
      state_nxt = scan_state_e'(dig_idx + 3'd1);
    end
  end

  // A load landing on the wrap cycle bypasses the shadow so it is not held a whole extra frame.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      shadow    <= '0;
      shadow_dp <= '0;
      pending   <= 1'b0;
      disp      <= '0;
      disp_dp   <= '0;
    end else begin
      if (load) begin
        shadow    <= data;
        shadow_dp <= dp;
      end
      if (wrap) begin
        pending <= 1'b0;
        if (load) begin
          disp    <= data;
          disp_dp <= dp;
        end else if (pending) begin
          disp    <= shadow;
          disp_dp <= shadow_dp;
        end
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  assign disp_sh = disp >> {dig_idx, 2'b00};

  always_comb begin
    seg_raw = {disp_dp[dig_idx], hex7(disp_sh[3:0])};
`ifdef SEG7_ZERO_BLANK_EN
    if ((dig_idx != 3'd0) && (disp_sh == 32'd0) && !disp_dp[dig_idx]) begin
      seg_raw = 8'h00;
    end
`endif
    loc_raw = 8'h01 << dig_idx;
    seg_nxt = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
    loc_nxt = AN_ACTIVE_LOW  ? ~loc_raw : loc_raw;
    if (!enable) begin
      seg_nxt = SEG_OFF;
      loc_nxt = AN_OFF;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      digitalLocation <= AN_OFF;
      digitalStates   <= SEG_OFF;
      scan_tick       <= 1'b0;
      frame_sync      <= 1'b0;
    end else begin
      digitalLocation <= loc_nxt;
      digitalStates   <= seg_nxt;
      scan_tick       <= adv;
      frame_sync      <= wrap;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a per-edge reference model pushes expected outputs, a monitor pops and compares.
// Honours SEG7_ZERO_BLANK_EN when the bundle is built with it.
module tb_seg7_scan_driver;

  localparam int D     = 4;
  localparam int FRAME = 8 * D;

  logic        Clock, Reset, load, enable;
  logic [31:0] data;
  logic [7:0]  dp;
  logic [7:0]  digitalLocation, digitalStates;
  logic        scan_tick, frame_sync;

  seg7_scan_driver #(.SCAN_DIV(D), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut (
    .Clock(Clock), .Reset(Reset), .load(load), .data(data), .dp(dp), .enable(enable),
    .digitalLocation(digitalLocation), .digitalStates(digitalStates),
    .scan_tick(scan_tick), .frame_sync(frame_sync)
  );

  typedef struct {
    logic [7:0] loc;
    logic [7:0] seg;
    logic       tick;
    logic       sync;
    logic       chk_seg;
  } exp_t;

  exp_t scb[$];
  int   vectors = 0;
  int   miscompares = 0;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model state: edges since reset release, shown word, most recent load and whether it is newer than the last commit.
  int          n = 0;
  int          idx;
  logic [31:0] m_disp = '0, m_last = '0, m_rest;
  logic [7:0]  m_dp = '0, m_last_dp = '0, raw;
  logic        fresh = 1'b0;
  exp_t        e_new, e_got;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    if (Reset) begin
      n = 0; m_disp = '0; m_dp = '0; m_last = '0; m_last_dp = '0; fresh = 1'b0;
      e_new = '{loc: 8'hFF, seg: 8'hFF, tick: 1'b0, sync: 1'b0, chk_seg: 1'b1};
    end else begin
      n++;
      idx    = ((n - 1) / D) % 8;
      m_rest = m_disp >> (4 * idx);
      raw    = {m_dp[idx], hex_tab[m_rest[3:0]]};
`ifdef SEG7_ZERO_BLANK_EN
      if (idx > 0 && m_rest == 32'd0 && !m_dp[idx]) raw = 8'h00;
`endif
      e_new.loc     = enable ? ~(8'h01 << idx) : 8'hFF;
      e_new.seg     = ~raw;
      e_new.chk_seg = enable;
      e_new.tick    = (n % D) == 0;
      e_new.sync    = (n % FRAME) == 0;
      if (load) begin
        m_last = data; m_last_dp = dp; fresh = 1'b1;
      end
      if ((n % FRAME) == 0 && fresh) begin
        m_disp = m_last; m_dp = m_last_dp; fresh = 1'b0;
      end
    end
    scb.push_back(e_new);
  end

  always @(negedge Clock) begin
    if (scb.size() > 0) begin
      e_got = scb.pop_front();
      vectors++;
      if (digitalLocation !== e_got.loc || (e_got.chk_seg && digitalStates !== e_got.seg) ||
          scan_tick !== e_got.tick || frame_sync !== e_got.sync) begin
        miscompares++;
        $display("FAIL outputs edge=%0d loc=%h exp %h seg=%h exp %h (chk=%b) tick=%b exp %b sync=%b exp %b",
                 n, digitalLocation, e_got.loc, digitalStates, e_got.seg, e_got.chk_seg,
                 scan_tick, e_got.tick, frame_sync, e_got.sync);
      end
    end
  end

  task automatic step(input int k);
    repeat (k) @(negedge Clock);
    #1;
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] p);
    data = d; dp = p; load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  initial begin
    Reset = 1'b0; load = 1'b0; data = '0; dp = '0; enable = 1'b1;
    #1 Reset = 1'b1;
    step(3);
    Reset = 1'b0;
    step(10);

    do_load(32'h0123_ABCD, 8'h00);
    step(80);

    do_load(32'h1111_1111, 8'h00);
    step(3);
    do_load(32'h2222_2222, 8'h00);
    step(70);

    for (int i = 0; i < 2 * FRAME && ((n + 1) % FRAME) != 0; i++) step(1);
    do_load(32'hCAFE_F00D, 8'h5A);
    step(70);

    enable = 1'b0;
    step(10);
    enable = 1'b1;
    step(40);

    do_load(32'h0000_00A5, 8'h00);
    step(70);
    do_load(32'h0000_00A5, 8'h10);
    step(70);

    do_load(32'h8765_4321, 8'h81);
    step(13);
    Reset = 1'b1;
    step(2);
    Reset = 1'b0;
    step(40);

    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        data = $urandom >> $urandom_range(0, 31);
        dp   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      enable = ($urandom_range(0, 15) != 0);
      step(1);
    end
    load = 1'b0; enable = 1'b1;
    step(5);

    if (vectors < 1500) begin
      miscompares++;
      $display("FAIL vector_count got %0d need >= 1500", vectors);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
